// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: one valid/ready/data channel.
// master drives valid and data and samples ready; slave does the reverse.
interface pipe_stage_reg_if #(
    parameter int WIDTH = 192
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input  ready);
    modport slave  (input  valid, input  data,  output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: two-entry skid-buffered pipeline register.
//
// The head entry sits in main_q and always drives out_data. skid_q catches a
// second word when the head is stalled. in_ready is decoded from the
// registered state only, so there is no combinational ready path from
// downstream to upstream.
//
// Optional feature: define PIPE_STAGE_STALL_CNT_EN to build a 32-bit counter
// of back-pressure cycles (out_valid & !out_ready). The counter is cleared
// only by reset. Without the macro, stall_cnt_o is tied to zero.
module pipe_stage_reg #(
    parameter int               WIDTH    = 192,
    parameter logic [WIDTH-1:0] CLR_DATA = '0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clr_i,
    pipe_stage_reg_if.slave        in_if,
    pipe_stage_reg_if.master       out_if,
    output logic [1:0]             occupancy_o,
    output logic [31:0]            stall_cnt_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    logic in_ready;
    logic out_valid;
    logic in_fire;
    logic out_fire;

    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign in_fire   = in_if.valid & in_ready;
    assign out_fire  = out_valid & out_if.ready;

    assign in_if.ready  = in_ready;
    assign out_if.valid = out_valid;
    assign out_if.data  = main_q;

    // The state encoding is the entry count.
    assign occupancy_o = state_q;

    // Occupancy FSM and data registers. Data registers are written only on a
    // fire, so an emptied register keeps its last value.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            main_q  <= CLR_DATA;
            skid_q  <= CLR_DATA;
        end else if (clr_i) begin
            // Flush: drop both entries and any word offered in this cycle.
            state_q <= EMPTY;
            main_q  <= CLR_DATA;
            skid_q  <= CLR_DATA;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_q <= ONE;
                        main_q  <= in_if.data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_if.data;
                    end else if (in_fire) begin
                        state_q <= TWO;
                        skid_q  <= in_if.data;
                    end else if (out_fire) begin
                        state_q <= EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low, so only the head can leave.
                    if (out_fire) begin
                        state_q <= ONE;
                        main_q  <= skid_q;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    // Count every back-pressured cycle. The counter wraps naturally and
    // ignores clr.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else if (out_valid && !out_if.ready) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed scenarios plus a randomized run checked against
// a queue model of a two-deep FIFO.
module tb_pipe_stage_reg;

    localparam int               W   = 64;
    localparam logic [W-1:0]     CLR = 64'hDEAD_BEEF_0BAD_F00D;

    logic        clk;
    logic        rst;
    logic        clr;
    logic [1:0]  occupancy;
    logic [31:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    pipe_stage_reg_if #(.WIDTH(W)) in_if ();
    pipe_stage_reg_if #(.WIDTH(W)) out_if ();

    pipe_stage_reg #(.WIDTH(W), .CLR_DATA(CLR)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .clr_i       (clr),
        .in_if       (in_if),
        .out_if      (out_if),
        .occupancy_o (occupancy),
        .stall_cnt_o (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic ordy);
        in_if.valid  = v;
        in_if.data   = d;
        out_if.ready = ordy;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clr = 1'b0;
        drive(1'b0, '0, 1'b0);
        #2;
        checks++;
        if (out_if.valid !== 1'b0 || in_if.ready !== 1'b1 || occupancy !== 2'd0 ||
            out_if.data !== CLR || stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: valid=%b ready=%b occ=%0d data=%h cnt=%0d, want 0 1 0 %h 0",
                     out_if.valid, in_if.ready, occupancy, out_if.data, stall_cnt, CLR);
        end
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, W'(i), 1'b1);
            tick();
            checks++;
            if (out_if.data !== W'(i) || occupancy !== 2'd1 || in_if.ready !== 1'b1 ||
                out_if.valid !== 1'b1) begin
                errors++;
                $display("FAIL stream_%0d: data=%h occ=%0d ready=%b, want %h 1 1",
                         i, out_if.data, occupancy, in_if.ready, W'(i));
            end
        end
        drive(1'b0, '0, 1'b1);
        tick();
        checks++;
        if (occupancy !== 2'd0 || out_if.valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_drain: occ=%0d valid=%b, want 0 0", occupancy, out_if.valid);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] exp_seq [3];
        exp_seq[0] = 64'h11;
        exp_seq[1] = 64'h22;
        exp_seq[2] = 64'h33;
        do_reset();
        drive(1'b1, 64'h11, 1'b0);
        tick();
        drive(1'b1, 64'h22, 1'b0);
        tick();
        checks++;
        if (occupancy !== 2'd2 || in_if.ready !== 1'b0 || out_if.data !== 64'h11) begin
            errors++;
            $display("FAIL bp_full: occ=%0d ready=%b data=%h, want 2 0 11",
                     occupancy, in_if.ready, out_if.data);
        end
        drive(1'b1, 64'h33, 1'b0);
        tick();
        checks++;
        if (occupancy !== 2'd2 || out_if.data !== 64'h11) begin
            errors++;
            $display("FAIL bp_hold: occ=%0d data=%h, want 2 11", occupancy, out_if.data);
        end
        // Release: 0x22 moves up, then 0x33 is taken while 0x22 leaves.
        out_if.ready = 1'b1;
        for (int i = 1; i < 3; i++) begin
            tick();
            checks++;
            if (out_if.data !== exp_seq[i] || out_if.valid !== 1'b1 || occupancy !== 2'd1) begin
                errors++;
                $display("FAIL bp_order_%0d: data=%h valid=%b occ=%0d, want %h 1 1",
                         i, out_if.data, out_if.valid, occupancy, exp_seq[i]);
            end
        end
        drive(1'b0, '0, 1'b1);
        tick();
        checks++;
        if (occupancy !== 2'd0) begin
            errors++;
            $display("FAIL bp_empty: occ=%0d, want 0", occupancy);
        end
    endtask

    task automatic test_clr();
        do_reset();
        drive(1'b1, 64'h1, 1'b0);
        tick();
        drive(1'b1, 64'h2, 1'b0);
        tick();
        drive(1'b1, 64'h44, 1'b0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if (occupancy !== 2'd0 || out_if.valid !== 1'b0 || out_if.data !== CLR ||
            in_if.ready !== 1'b1) begin
            errors++;
            $display("FAIL clr_flush: occ=%0d valid=%b data=%h ready=%b, want 0 0 %h 1",
                     occupancy, out_if.valid, out_if.data, in_if.ready, CLR);
        end
        drive(1'b0, '0, 1'b1);
        tick();
        checks++;
        if (occupancy !== 2'd0 || out_if.valid !== 1'b0) begin
            errors++;
            $display("FAIL clr_no_capture: occ=%0d valid=%b, want 0 0", occupancy, out_if.valid);
        end
    endtask

    task automatic test_async_reset_two();
        do_reset();
        drive(1'b1, 64'hA, 1'b0);
        tick();
        drive(1'b1, 64'hB, 1'b0);
        tick();
        checks++;
        if (occupancy !== 2'd2 || out_if.data !== 64'hA) begin
            errors++;
            $display("FAIL arst_setup: occ=%0d data=%h, want 2 a", occupancy, out_if.data);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_if.valid !== 1'b0 || in_if.ready !== 1'b1 || occupancy !== 2'd0 ||
            out_if.data !== CLR || stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL arst_immediate: valid=%b ready=%b occ=%0d data=%h cnt=%0d, want 0 1 0 %h 0",
                     out_if.valid, in_if.ready, occupancy, out_if.data, stall_cnt, CLR);
        end
        #2;
        rst = 1'b0;
        drive(1'b1, 64'hC, 1'b0);
        tick();
        checks++;
        if (occupancy !== 2'd1 || out_if.data !== 64'hC) begin
            errors++;
            $display("FAIL arst_first_fire: occ=%0d data=%h, want 1 c", occupancy, out_if.data);
        end
    endtask

    task automatic test_stall_cnt();
        logic [31:0] exp5;
`ifdef PIPE_STAGE_STALL_CNT_EN
        exp5 = 32'd5;
`else
        exp5 = 32'd0;
`endif
        do_reset();
        drive(1'b1, 64'h5, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0);
        repeat (5) tick();
        checks++;
        if (stall_cnt !== exp5) begin
            errors++;
            $display("FAIL stall_count: cnt=%0d, want %0d", stall_cnt, exp5);
        end
        // Flush while the head is consumed, so this edge is not a stall.
        out_if.ready = 1'b1;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        checks++;
        if (stall_cnt !== exp5 || occupancy !== 2'd0) begin
            errors++;
            $display("FAIL stall_after_clr: cnt=%0d occ=%0d, want %0d 0", stall_cnt, occupancy, exp5);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] q[$];
        logic [31:0]  exp_cnt;
        logic         m_ready, m_valid, fire_in, fire_out;
        do_reset();
        exp_cnt = 32'd0;
        for (int n = 0; n < 500; n++) begin
            drive(($urandom % 4) != 0, {$urandom(), $urandom()}, ($urandom % 3) != 0);
            clr = (($urandom % 32) == 0);
            #1;
            m_ready = (q.size() < 2);
            m_valid = (q.size() > 0);
            checks++;
            if (in_if.ready !== m_ready || out_if.valid !== m_valid ||
                (m_valid && out_if.data !== q[0])) begin
                errors++;
                $display("FAIL rand_pre_%0d: ready=%b valid=%b data=%h, want %b %b %h",
                         n, in_if.ready, out_if.valid, out_if.data, m_ready, m_valid,
                         m_valid ? q[0] : out_if.data);
            end
            fire_in  = in_if.valid && m_ready;
            fire_out = m_valid && out_if.ready;
`ifdef PIPE_STAGE_STALL_CNT_EN
            if (m_valid && !out_if.ready) exp_cnt = exp_cnt + 32'd1;
`endif
            if (clr) begin
                q.delete();
            end else begin
                if (fire_out) void'(q.pop_front());
                if (fire_in) q.push_back(in_if.data);
            end
            tick();
            checks++;
            if (occupancy !== 2'(q.size()) || stall_cnt !== exp_cnt ||
                (clr && out_if.data !== CLR)) begin
                errors++;
                $display("FAIL rand_post_%0d: occ=%0d cnt=%0d data=%h, want occ=%0d cnt=%0d clr=%b",
                         n, occupancy, stall_cnt, out_if.data, q.size(), exp_cnt, clr);
            end
            clr = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_clr();
        test_async_reset_two();
        test_stall_cnt();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
